// File: rtl/sim_status_monitor.sv
// End-of-test monitor: watches regfile write-backs for a PASS/FAIL signature,
// enforces a run-cycle budget, and counts cycles and retired instructions.
module sim_status_monitor #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned NUM_WB_PORTS   = 2,
  parameter int unsigned SIG_REG        = 31,
  parameter int unsigned PASS_CODE      = 666,
  parameter int unsigned FAIL_CODE      = 404,
  parameter int unsigned MAX_CYC        = 600,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                                   cpu_clk,
  input  logic                                   cpu_rst,
  input  logic                                   start,
  input  logic [NUM_WB_PORTS-1:0]                wb_we,
  input  logic [NUM_WB_PORTS*REG_ADDR_WIDTH-1:0] wb_addr,
  input  logic [NUM_WB_PORTS*DATA_WIDTH-1:0]     wb_data,
  input  logic [NUM_WB_PORTS-1:0]                inst_retire,
  output logic [2:0]                             status,
  output logic                                   done,
  output logic                                   halt_req,
  output logic [CNT_WIDTH-1:0]                   cycle_cnt,
  output logic [CNT_WIDTH-1:0]                   retire_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_t;

  localparam int unsigned POP_W = $clog2(NUM_WB_PORTS + 1);
  localparam logic [REG_ADDR_WIDTH-1:0] SIG_ADDR = REG_ADDR_WIDTH'(SIG_REG);
  localparam logic [DATA_WIDTH-1:0]     PASS_VAL = DATA_WIDTH'(PASS_CODE);
  localparam logic [DATA_WIDTH-1:0]     FAIL_VAL = DATA_WIDTH'(FAIL_CODE);
  localparam logic [CNT_WIDTH-1:0]      LAST_CYC = CNT_WIDTH'(MAX_CYC - 1);
  localparam logic [CNT_WIDTH-1:0]      CNT_MAX  = '1;

  state_t               state;
  logic                 hit;
  logic                 hit_pass;
  logic                 timeout_now;
  logic [POP_W-1:0]     pop;
  logic [CNT_WIDTH:0]   cycle_sum;
  logic [CNT_WIDTH:0]   retire_sum;
  logic [CNT_WIDTH-1:0] cycle_next;
  logic [CNT_WIDTH-1:0] retire_next;

  // Later ports overwrite earlier ones, so the youngest hit decides the verdict.
  always_comb begin
    hit      = 1'b0;
    hit_pass = 1'b0;
    pop      = '0;
    for (int i = 0; i < NUM_WB_PORTS; i++) begin
      if (wb_we[i] && wb_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == SIG_ADDR &&
          wb_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] != '0) begin
        if (wb_data[i*DATA_WIDTH +: DATA_WIDTH] == PASS_VAL) begin
          hit      = 1'b1;
          hit_pass = 1'b1;
        end else if (wb_data[i*DATA_WIDTH +: DATA_WIDTH] == FAIL_VAL) begin
          hit      = 1'b1;
          hit_pass = 1'b0;
        end
      end
      pop = pop + POP_W'(inst_retire[i]);
    end
  end

  assign cycle_sum   = {1'b0, cycle_cnt} + (CNT_WIDTH+1)'(1);
  assign retire_sum  = {1'b0, retire_cnt} + (CNT_WIDTH+1)'(pop);
  assign cycle_next  = cycle_sum[CNT_WIDTH]  ? CNT_MAX : cycle_sum[CNT_WIDTH-1:0];
  assign retire_next = retire_sum[CNT_WIDTH] ? CNT_MAX : retire_sum[CNT_WIDTH-1:0];
  assign timeout_now = (MAX_CYC != 0) && (cycle_cnt == LAST_CYC);

  // IDLE and the terminal states share one branch: both hold until start.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state      <= ST_IDLE;
      done       <= 1'b0;
      cycle_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (start) begin
            cycle_cnt  <= '0;
            retire_cnt <= '0;
          end else begin
            cycle_cnt  <= cycle_next;
            retire_cnt <= retire_next;
            if (hit) begin
              state <= hit_pass ? ST_PASS : ST_FAIL;
              done  <= 1'b1;
            end else if (timeout_now) begin
              state <= ST_TIMEOUT;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          if (start) begin
            state      <= ST_RUN;
            done       <= 1'b0;
            cycle_cnt  <= '0;
            retire_cnt <= '0;
          end
        end
      endcase
    end
  end

  assign status   = state;
  assign halt_req = done;

endmodule
